// File: rtl/mem_access_stage_pkg.sv
// Shared op codes, FSM encodings and store-merge helper
// for the MEM pipeline stage.
package mem_access_stage_pkg;

    localparam int DEF_DATA_W = 32;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RMW_WR = 1'b1;

    // Replace one byte or halfword lane of a word with store data.
    function automatic logic [31:0] merge_lane(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic        half,
        input logic [15:0] data
    );
        logic [31:0] r;
        r = word;
        if (half) begin
            if (lane[1]) r[31:16] = data;
            else         r[15:0]  = data;
        end else begin
            unique case (lane)
                2'd0: r[7:0]   = data[7:0];
                2'd1: r[15:8]  = data[7:0];
                2'd2: r[23:16] = data[7:0];
                2'd3: r[31:24] = data[7:0];
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align_ext.sv
// Load lane selection with sign/zero extension.
// Purely combinational.
module load_align_ext
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [3:0]  i_op,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed lane, then extend per op.
    always_comb begin
        w_byte = i_word[7:0];
        unique case (i_lane)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
        o_data = i_word;
        unique case (1'b1)
            (i_op == MEM_LB):  o_data = {{24{w_byte[7]}}, w_byte};
            (i_op == MEM_LBU): o_data = {24'd0, w_byte};
            (i_op == MEM_LH):  o_data = {{16{w_half[15]}}, w_half};
            (i_op == MEM_LHU): o_data = {16'd0, w_half};
            default:           o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: word memory port, sub-word loads, RMW
// sub-word stores, MEM/WB register, misalign flag.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic [3:0]           ex_mem_op,
    input  logic                 ex_reg_we,
    input  logic [RF_ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0]    ex_result,
    input  logic [DATA_W-1:0]    ex_store_data,
    output logic                 stall_o,
    output logic                 mem_we,
    output logic [DATA_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 wb_valid,
    output logic [RF_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 misalign_exc
);

    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] r_addr;
    logic [1:0]        r_lane;
    logic              r_half;
    logic [15:0]       r_sdata;

    logic              w_idle;
    logic              w_is_load;
    logic              w_is_sub;
    logic              w_is_sw;
    logic              w_mis;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merge;

    assign w_idle = (r_state == ST_IDLE);

    // Classify the op and detect misalignment.
    always_comb begin
        w_is_load = 1'b0;
        w_is_sub  = 1'b0;
        w_is_sw   = 1'b0;
        w_mis     = 1'b0;
        unique case (1'b1)
            (ex_mem_op == MEM_LB),
            (ex_mem_op == MEM_LBU): w_is_load = 1'b1;
            (ex_mem_op == MEM_LH),
            (ex_mem_op == MEM_LHU): begin
                w_is_load = 1'b1;
                w_mis     = ex_result[0];
            end
            (ex_mem_op == MEM_LW): begin
                w_is_load = 1'b1;
                w_mis     = |ex_result[1:0];
            end
            (ex_mem_op == MEM_SB): w_is_sub = 1'b1;
            (ex_mem_op == MEM_SH): begin
                w_is_sub = 1'b1;
                w_mis    = ex_result[0];
            end
            (ex_mem_op == MEM_SW): begin
                w_is_sw = 1'b1;
                w_mis   = |ex_result[1:0];
            end
            default: ;
        endcase
    end

    load_align_ext u_load (
        .i_word (mem_rdata),
        .i_lane (ex_result[1:0]),
        .i_op   (ex_mem_op),
        .o_data (w_load)
    );

    assign w_merge = merge_lane(r_word, r_lane, r_half, r_sdata);

    // Memory port and stall; gated low while in reset.
    always_comb begin
        stall_o   = rst_n & w_idle & ex_valid & w_is_sub & ~w_mis;
        mem_we    = rst_n & ((w_idle & ex_valid & w_is_sw & ~w_mis)
                             | ~w_idle);
        mem_addr  = w_idle ? {ex_result[DATA_W-1:2], 2'b00} : r_addr;
        mem_wdata = w_idle ? ex_store_data : w_merge;
    end

    // FSM, RMW capture and MEM/WB register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_word       <= '0;
            r_addr       <= '0;
            r_lane       <= '0;
            r_half       <= 1'b0;
            r_sdata      <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            misalign_exc <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_exc <= 1'b0;
            if (!w_idle) begin
                r_state <= ST_IDLE;
            end else if (ex_valid) begin
                if (w_mis) begin
                    misalign_exc <= 1'b1;
                end else if (w_is_load) begin
                    wb_valid <= ex_reg_we;
                    wb_rd    <= ex_rd;
                    wb_data  <= w_load;
                end else if (w_is_sub) begin
                    r_state <= ST_RMW_WR;
                    r_word  <= mem_rdata;
                    r_addr  <= {ex_result[DATA_W-1:2], 2'b00};
                    r_lane  <= ex_result[1:0];
                    r_half  <= (ex_mem_op == MEM_SH);
                    r_sdata <= ex_store_data[15:0];
                end else if (!w_is_sw) begin
                    wb_valid <= ex_reg_we;
                    wb_rd    <= ex_rd;
                    wb_data  <= ex_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with an
// instruction-level reference model and memory.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [3:0]  ex_mem_op = 4'd0;
    logic        ex_reg_we = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic [31:0] ex_result = 32'd0;
    logic [31:0] ex_store_data = 32'd0;
    logic        stall_o, mem_we, wb_valid, misalign_exc;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, wb_data;
    logic [4:0]  wb_rd;

    logic [31:0] mem [0:63];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_idx = 6'd0;
    logic [31:0] bd_data = 32'd0;

    logic [31:0] mdl [0:63];
    logic        exp_valid, exp_mis, exp_stall, exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data, exp_addr, exp_wdata;
    logic        nxt_valid, nxt_mis;
    logic [4:0]  nxt_rd;
    logic [31:0] nxt_data;
    logic        chk_en = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_mem_op     (ex_mem_op),
        .ex_reg_we     (ex_reg_we),
        .ex_rd         (ex_rd),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .stall_o       (stall_o),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .misalign_exc  (misalign_exc)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_o", stall_o, exp_stall);
            chk("mem_we", mem_we, exp_we);
            if (exp_we) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_wdata", mem_wdata, exp_wdata);
            end
            chk("wb_valid", wb_valid, exp_valid);
            if (exp_valid) begin
                chk("wb_rd", wb_rd, exp_rd);
                chk("wb_data", wb_data, exp_data);
            end
            chk("misalign_exc", misalign_exc, exp_mis);
        end
    end

    function automatic logic [31:0] model_load(input logic [3:0] op,
        input logic [31:0] w, input logic [1:0] a);
        logic [31:0] v;
        v = w;
        if (op == MEM_LB || op == MEM_LBU) begin
            v = (w >> (8 * a)) & 32'hFF;
            if (op == MEM_LB && v >= 128) v = v - 256;
        end else if (op == MEM_LH || op == MEM_LHU) begin
            v = (w >> (8 * a)) & 32'hFFFF;
            if (op == MEM_LH && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [3:0] op,
        input logic [31:0] w, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] m;
        m = ((op == MEM_SB) ? 32'hFF : 32'hFFFF) << (8 * a);
        return (w & ~m) | ((d << (8 * a)) & m);
    endfunction

    task automatic advance();
        @(posedge clk);
        #1;
        exp_valid = nxt_valid;
        exp_rd    = nxt_rd;
        exp_data  = nxt_data;
        exp_mis   = nxt_mis;
        nxt_mis   = 1'b0;
        nxt_valid = 1'b0;
    endtask

    task automatic nop();
        advance();
        ex_valid  = 1'b0;
        exp_stall = 1'b0;
        exp_we    = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr,
        input logic [31:0] sd, input logic [4:0] rd, input logic we);
        logic [1:0]  a;
        logic [31:0] word;
        logic        mis;
        advance();
        ex_valid = 1'b1;
        ex_mem_op = op;
        ex_result = addr;
        ex_store_data = sd;
        ex_rd = rd;
        ex_reg_we = we;
        a = addr[1:0];
        word = mdl[addr[7:2]];
        mis = ((op == MEM_LW || op == MEM_SW) && a != 2'd0) ||
              ((op == MEM_LH || op == MEM_LHU || op == MEM_SH) && a[0]);
        exp_stall = 1'b0;
        exp_we = 1'b0;
        exp_addr = {addr[31:2], 2'b00};
        if (mis) begin
            nxt_mis = 1'b1;
        end else if (op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU}) begin
            nxt_valid = we;
            nxt_rd = rd;
            nxt_data = model_load(op, word, a);
        end else if (op == MEM_SW) begin
            exp_we = 1'b1;
            exp_wdata = sd;
            mdl[addr[7:2]] = sd;
        end else if (op == MEM_SB || op == MEM_SH) begin
            exp_stall = 1'b1;
            advance();
            exp_stall = 1'b0;
            exp_we = 1'b1;
            exp_wdata = model_merge(op, word, a, sd);
            mdl[addr[7:2]] = exp_wdata;
        end else begin
            nxt_valid = we;
            nxt_rd = rd;
            nxt_data = addr;
        end
    endtask

    task automatic clear_model();
        exp_valid = 0; exp_rd = 0; exp_data = 0; exp_mis = 0;
        exp_stall = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0;
        nxt_valid = 0; nxt_rd = 0; nxt_data = 0; nxt_mis = 0;
    endtask

    task automatic async_reset(input string tag);
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({tag, " wb_valid"}, wb_valid, 32'd0);
        chk({tag, " wb_rd"}, wb_rd, 32'd0);
        chk({tag, " wb_data"}, wb_data, 32'd0);
        chk({tag, " misalign"}, misalign_exc, 32'd0);
        chk({tag, " mem_we"}, mem_we, 32'd0);
        chk({tag, " stall"}, stall_o, 32'd0);
        ex_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        chk_en = 1'b1;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] d);
        @(posedge clk);
        #1;
        bd_we = 1'b1;
        bd_idx = idx;
        bd_data = d;
        mdl[idx] = d;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
    endtask

    logic [31:0] saved;

    initial begin
        clear_model();
        for (int i = 0; i < 64; i++) mdl[i] = 32'd0;
        for (int i = 0; i < 64; i++) preload(i[5:0], 32'd0);
        preload(6'd8, 32'h80F17F02);
        preload(6'd12, 32'h11223344);
        #1;
        chk("reset wb_valid", wb_valid, 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        chk("reset mem_we", mem_we, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        issue(MEM_SW, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0);
        @(negedge clk);
        chk("sw mem_we", mem_we, 32'd1);
        issue(MEM_LW, 32'h10, 32'd0, 5'd5, 1'b1);
        nop();
        @(negedge clk);
        chk("lw wb_valid", wb_valid, 32'd1);
        chk("lw wb_rd", wb_rd, 32'd5);
        chk("lw wb_data", wb_data, 32'hDEADBEEF);

        issue(MEM_LB, 32'h23, 32'd0, 5'd1, 1'b1);
        nop();
        @(negedge clk);
        chk("lb 0x23", wb_data, 32'hFFFFFF80);
        issue(MEM_LBU, 32'h23, 32'd0, 5'd2, 1'b1);
        nop();
        @(negedge clk);
        chk("lbu 0x23", wb_data, 32'h00000080);
        issue(MEM_LH, 32'h22, 32'd0, 5'd3, 1'b1);
        nop();
        @(negedge clk);
        chk("lh 0x22", wb_data, 32'hFFFF80F1);
        issue(MEM_LHU, 32'h20, 32'd0, 5'd4, 1'b1);
        nop();
        @(negedge clk);
        chk("lhu 0x20", wb_data, 32'h00007F02);
        issue(MEM_LB, 32'h21, 32'd0, 5'd6, 1'b1);
        issue(MEM_LBU, 32'h22, 32'd0, 5'd7, 1'b1);
        issue(MEM_LH, 32'h20, 32'd0, 5'd8, 1'b0);

        issue(MEM_SB, 32'h31, 32'h000000AB, 5'd0, 1'b0);
        @(negedge clk);
        chk("sb rmw mem_we", mem_we, 32'd1);
        chk("sb rmw wdata", mem_wdata, 32'h1122AB44);
        issue(MEM_LW, 32'h30, 32'd0, 5'd7, 1'b1);
        nop();
        @(negedge clk);
        chk("lw after sb", wb_data, 32'h1122AB44);

        issue(MEM_SH, 32'h22, 32'h0000BEEF, 5'd0, 1'b0);
        issue(MEM_LW, 32'h20, 32'd0, 5'd9, 1'b1);
        issue(MEM_SW, 32'h14, 32'hCAFEF00D, 5'd0, 1'b0);
        issue(MEM_LHU, 32'h16, 32'd0, 5'd10, 1'b1);
        issue(MEM_NONE, 32'h12345678, 32'd0, 5'd11, 1'b1);
        issue(4'd12, 32'h0BADC0DE, 32'd0, 5'd12, 1'b1);
        issue(MEM_NONE, 32'h5, 32'd0, 5'd13, 1'b0);

        issue(MEM_LW, 32'h42, 32'd0, 5'd3, 1'b1);
        nop();
        @(negedge clk);
        chk("lw misalign pulse", misalign_exc, 32'd1);
        issue(MEM_SH, 32'h45, 32'h1234, 5'd0, 1'b0);
        nop();
        nop();
        @(negedge clk);
        chk("misalign cleared", misalign_exc, 32'd0);

        issue(MEM_LW, 32'h10, 32'd0, 5'd5, 1'b1);
        nop();
        #2;
        async_reset("midrun");

        saved = mdl[12];
        issue(MEM_SH, 32'h32, 32'h00005555, 5'd0, 1'b0);
        mdl[12] = saved;
        #2;
        chk("rmw we before reset", mem_we, 32'd1);
        async_reset("rmw");
        issue(MEM_LW, 32'h30, 32'd0, 5'd4, 1'b1);
        nop();
        @(negedge clk);
        chk("word kept after rmw reset", wb_data, 32'h1122AB44);
        chk("rmw idle stall", stall_o, 32'd0);
        nop();
        nop();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
